// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM states, forwarding select codes and defaults for hazard control
package pipe_pkg;
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: selects one ALU operand source, nearest producer wins, x0 never forwards
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_regwrite,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_regwrite,
  output logic [1:0] sel
);
  // EX/MEM is younger than MEM/WB so it takes precedence
  always_comb begin
    sel = (rs == 5'd0) ? FWD_RF :
          (exmem_regwrite && exmem_rd == rs) ? FWD_EXMEM :
          (memwb_regwrite && memwb_rd == rs) ? FWD_MEMWB : FWD_RF;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, flush, memory-wait and forwarding control for a 5-stage pipeline
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  idex_rs1,
  input  logic [4:0]  idex_rs2,
  input  logic [4:0]  idex_rd,
  input  logic        idex_memread,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic        memwb_regwrite,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_hold,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt, wait_cnt_nx;
  logic          freeze, timeout_hit, load_use;
  // next state, wait counter and Mealy stall/flush outputs; reset forces a bubble
  always_comb begin
    timeout_hit = state == MEM_WAIT && !mem_ready && wait_cnt == CW'(TIMEOUT);
    freeze      = !mem_ready && ((state == RUN) ? mem_req : !timeout_hit);
    load_use    = idex_memread && idex_rd != 5'd0 && (idex_rd == id_rs1 || idex_rd == id_rs2);
    state_nx    = freeze ? MEM_WAIT : RUN;
    wait_cnt_nx = (state == MEM_WAIT && freeze) ? wait_cnt + 1'b1 : '0;
    pc_write    = rst && !freeze && (ex_branch_taken || !load_use);
    ifid_write  = pc_write;
    ifid_flush  = !rst || (!freeze && ex_branch_taken);
    idex_flush  = !rst || (!freeze && (ex_branch_taken || load_use));
    pipe_hold   = rst && freeze;
  end
  // state, wait counter, sticky timeout flag and saturating stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_cnt_nx;
      mem_timeout <= mem_timeout || timeout_hit;
      stall_cnt   <= (!pc_write && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
    end
  end
  fwd_unit u_fwd_a (
    .rs(idex_rs1), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .sel(forward_a)
  );
  fwd_unit u_fwd_b (
    .rs(idex_rs2), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .sel(forward_b)
  );
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 255, maximum MEM_WAIT cycles before abandoning a memory access.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: id_rs1  in  5  ID-stage source register 1.
REQ-005 SHALL have port: id_rs2  in  5  ID-stage source register 2.
REQ-006 SHALL have port: idex_rs1  in  5  RS1 held in ID/EX.
REQ-007 SHALL have port: idex_rs2  in  5  RS2 held in ID/EX.
REQ-008 SHALL have port: idex_rd  in  5  RD held in ID/EX.
REQ-009 SHALL have port: idex_memread  in  1  ID/EX instruction is a load.
REQ-010 SHALL have port: exmem_rd  in  5  RD held in EX/MEM.
REQ-011 SHALL have port: exmem_regwrite  in  1  EX/MEM writes a register.
REQ-012 SHALL have port: memwb_rd  in  5  RD held in MEM/WB.
REQ-013 SHALL have port: memwb_regwrite  in  1  MEM/WB writes a register.
REQ-014 SHALL have port: ex_branch_taken  in  1  branch resolved taken in EX.
REQ-015 SHALL have port: mem_req  in  1  EX/MEM holds a memory access.
REQ-016 SHALL have port: mem_ready  in  1  data memory completes the access this cycle.
REQ-017 SHALL have port: pc_write  out  1  PC update enable.
REQ-018 SHALL have port: ifid_write  out  1  IF/ID load enable.
REQ-019 SHALL have port: ifid_flush  out  1  IF/ID clear to bubble.
REQ-020 SHALL have port: idex_flush  out  1  ID/EX clear control bits to bubble.
REQ-021 SHALL have port: pipe_hold  out  1  freeze ID/EX and EX/MEM.
REQ-022 SHALL have port: forward_a, forward_b  out  2 each  ALU operand source select: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-023 SHALL have port: mem_timeout  out  1  sticky access-abandoned flag.
REQ-024 SHALL have port: stall_cnt  out  16  saturating count of cycles with pc_write=0.

Function
REQ-025 SHALL implement a two-state FSM: RUN and MEM_WAIT; all stall/flush outputs are Mealy, combinational from state and inputs.
REQ-026 SHALL, in RUN with mem_req=1 and mem_ready=0: freeze the pipeline (pc_write=0, ifid_write=0, pipe_hold=1, no flushes); next state MEM_WAIT; wait counter cleared.
REQ-027 SHALL, in MEM_WAIT with mem_ready=0: freeze as in REQ-026 and increment the wait counter.
REQ-028 SHALL, in MEM_WAIT with mem_ready=1: release the freeze and apply RUN rules in the same cycle; next state RUN.
REQ-029 SHALL, in MEM_WAIT when the wait counter equals TIMEOUT and mem_ready=0: set mem_timeout; release the freeze; next state RUN.
REQ-030 SHALL, while frozen, ignore ex_branch_taken and load-use; both are re-evaluated on release because the held stages keep them stable.
REQ-031 SHALL, when not frozen and ex_branch_taken=1: set ifid_flush=1 and idex_flush=1 with pc_write=1.
REQ-032 SHALL detect load-use when not frozen, with no taken branch, idex_memread=1, idex_rd!=0, and idex_rd equal to id_rs1 or id_rs2.
REQ-033 SHALL, on load-use: set pc_write=0, ifid_write=0, idex_flush=1; this is a one-cycle bubble with no state change.
REQ-034 SHALL apply priority: freeze > branch flush > load-use > normal (pc_write=1, ifid_write=1, all others 0).
REQ-035 SHALL select forward_a=10 when exmem_regwrite=1, exmem_rd!=0 and exmem_rd==idex_rs1.
REQ-036 SHALL otherwise select forward_a=01 when memwb_regwrite=1, memwb_rd!=0 and memwb_rd==idex_rs1; otherwise 00.
REQ-037 SHALL compute forward_b identically using idex_rs2; register x0 never forwards.
REQ-038 SHALL increment stall_cnt on each clock with pc_write=0 and saturate at 16'hFFFF.

Reset
REQ-039 SHALL, while rst=0, force: state=RUN, wait counter=0, mem_timeout=0, stall_cnt=0, pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_hold=0.
REQ-040 SHALL, on rst assertion mid-MEM_WAIT, abandon the wait immediately without setting mem_timeout; normal operation resumes on the first edge after release.

Structure
REQ-041 SHALL define in shared package pipe_pkg: the FSM state enum, forwarding select codes (FWD_RF, FWD_EXMEM, FWD_MEMWB), and the default TIMEOUT.
REQ-042 SHALL place operand-forwarding logic in combinational sub-module fwd_unit, instantiated twice (operands A and B).

Verification
REQ-043 SHALL cover: load x5 in ID/EX, id_rs1=5 -> one cycle pc_write=0, idex_flush=1; next cycle normal, stall_cnt=1.
REQ-044 SHALL cover: ex_branch_taken=1 -> ifid_flush=1, idex_flush=1, pc_write=1 in the same cycle.
REQ-045 SHALL cover: mem_req=1, mem_ready low for 3 cycles then high -> pipe_hold=1 for 3 cycles and 0 on the ready cycle; state returns to RUN.
REQ-046 SHALL cover: mem_ready never rises, TIMEOUT=4 -> mem_timeout=1 after exit from MEM_WAIT and stays high until rst.
REQ-047 SHALL cover: exmem_rd=memwb_rd=idex_rs1=7, both regwrite=1 -> forward_a=10; with exmem_rd=0 -> forward_a=01.
REQ-048 SHALL cover: rst=0 during MEM_WAIT -> state RUN, mem_timeout=0, stall_cnt=0 immediately.
